udp_vlg_tx: RTL and testbench
=============================

// Module: udp_vlg_tx
// PURPOSE
//  UDP transmitter. Accepts a datagram request (ports, payload length, destination IP) from the application,
//  arbitrates for the IPv4 TX path, then emits the 8-byte UDP header followed by the payload as a byte stream.
//  Payload is pulled from an upstream first-word-fallthrough buffer. Sits between the application/UDP mux and ipv4_vlg_tx.
// PARAMETERS
//  ACC_TIMEOUT  1000  cycles to wait for ipv4_acc after ipv4_req before aborting (>=2)
//  VERBOSE      1     1: $display one line per transmitted datagram
//  DUT_STRING   ""    prefix for $display
// PORTS
//  clk           in   1     clock
//  rst           in   1     synchronous active-high reset
//  req           in   1     start datagram; meta inputs sampled on the cycle req=1 while busy=0
//  src_port      in   16    UDP source port
//  dst_port      in   16    UDP destination port
//  pld_len       in   16    payload bytes, 1..1472; 0 rejected
//  cks           in   16    UDP checksum field (0 = not used)
//  dst_ip        in   32    destination IPv4 address
//  busy          out  1     request latched, datagram in progress
//  done          out  1     1-cycle pulse: datagram fully sent
//  err           out  1     1-cycle pulse: rejected request or ACC_TIMEOUT abort
//  pld_dat       in   8     payload byte (FWFT: valid while pld_rd is high)
//  pld_rd        out  1     payload byte consumed this cycle
//  ipv4_req      out  1     request IPv4 TX path
//  ipv4_acc      in   1     IPv4 TX accepted; stream starts next cycle
//  ipv4_len      out  16    IPv4 payload length = pld_len+8
//  ipv4_proto    out  8     constant 8'd17
//  ipv4_dst_ip   out  32    latched dst_ip
//  ipv4_dat      out  8     stream data
//  ipv4_val      out  1     stream byte valid
//  ipv4_sof      out  1     first byte of UDP datagram
//  ipv4_eof      out  1     last byte of UDP datagram
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; latched meta 0. rst mid-datagram aborts immediately; no done/err pulse.
//  FSM IDLE -> REQ -> HDR -> PLD -> IDLE.
//  IDLE: req=1 & pld_len in 1..1472 -> latch meta, busy=1, go REQ. req with pld_len=0 or >1472 -> err pulse, stay IDLE.
//    req while busy=1 is ignored.
//  REQ: ipv4_req=1, timer counts up. ipv4_acc=1 -> ipv4_req=0 next cycle, go HDR.
//    Timer reaches ACC_TIMEOUT-1 without acc -> err pulse, busy=0, IDLE. acc on the timeout cycle wins (go HDR).
//  HDR: 8 cycles, ipv4_val=1, bytes MSB-first: src_port[15:8], src_port[7:0], dst_port, length=pld_len+8, cks.
//    ipv4_sof=1 on byte 0 only. First HDR byte is the cycle after ipv4_acc.
//  PLD: pld_len cycles, pld_rd=1 and ipv4_val=1 each cycle; ipv4_dat=pld_dat (combinational pass, 0 latency).
//    16-bit down-counter; ipv4_eof=1 with the last payload byte.
//    Cycle after eof: done pulse, busy=0, IDLE; new req is accepted that same cycle.
//  Stream is gapless: val stays 1 from sof to eof, with exactly pld_len+8 val cycles. Upstream must hold pld_len bytes before req.
//  ipv4_len/proto/dst_ip are stable from REQ until done/err.
//  ipv4_dat=0 when ipv4_val=0.
//  Length arithmetic is 16-bit; the range check guarantees no overflow.
// TESTING
//  1. src 1234, dst 5678, pld_len 4, payload DE AD BE EF, acc after 3 cycles -> 12 bytes: 04 D2 16 2E 00 0C 00 00 DE AD BE EF;
//     sof on 04, eof on EF, done 1 cycle later, ipv4_len=12.
//  2. pld_len=1 -> 9-byte stream, sof and eof 8 cycles apart, pld_rd high exactly 1 cycle.
//  3. ipv4_acc never asserted, ACC_TIMEOUT=16 -> err pulse 16 cycles after ipv4_req rose, no ipv4_val, busy=0.
//  4. req with pld_len=0, then pld_len=1473 -> err pulse each, ipv4_req stays 0.
//  5. rst asserted during payload byte 2 of 10 -> all outputs 0 next cycle; the following req sends a full correct datagram.
//  6. Back-to-back: req held high -> second datagram's ipv4_req rises the cycle after first done; both checked byte-exact.

Source files
------------

// File: rtl/udp_vlg_tx.sv
// rtl/udp_vlg_tx.sv - UDP datagram transmitter: header generation and payload pass-through to IPv4 TX
module udp_vlg_tx #(
    parameter int ACC_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] pld_len,
    input  logic [15:0] cks,
    input  logic [31:0] dst_ip,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [7:0]  pld_dat,
    output logic        pld_rd,
    output logic        ipv4_req,
    input  logic        ipv4_acc,
    output logic [15:0] ipv4_len,
    output logic [7:0]  ipv4_proto,
    output logic [31:0] ipv4_dst_ip,
    output logic [7:0]  ipv4_dat,
    output logic        ipv4_val,
    output logic        ipv4_sof,
    output logic        ipv4_eof
);

    localparam int TW = $clog2(ACC_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HDR, S_PLD} state_t;

    state_t      state_q;
    logic [15:0] src_port_q;
    logic [15:0] dst_port_q;
    logic [15:0] cks_q;
    logic [15:0] ipv4_len_q;
    logic [31:0] dst_ip_q;
    logic [7:0]  proto_q;
    logic [TW-1:0] timer_q;
    logic [2:0]  hdr_idx_q;
    logic [15:0] pld_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        ipv4_req_q;
    logic        val_q;
    logic        sof_q;
    logic        eof_q;
    logic        pld_rd_q;
    logic [7:0]  hdr_dat_q;
    logic [7:0]  hdr_next_d;
    logic        len_ok_d;

    // Payload lengths accepted: 1..1472 bytes (fits one Ethernet frame without fragmentation)
    always_comb begin
        len_ok_d = (pld_len != 16'd0) && (pld_len <= 16'd1472);
    end

    // Header byte that follows the one currently on the stream (index = byte being shown)
    always_comb begin
        hdr_next_d = 8'h00;
        case (hdr_idx_q)
            3'd0: hdr_next_d = src_port_q[7:0];
            3'd1: hdr_next_d = dst_port_q[15:8];
            3'd2: hdr_next_d = dst_port_q[7:0];
            3'd3: hdr_next_d = ipv4_len_q[15:8];
            3'd4: hdr_next_d = ipv4_len_q[7:0];
            3'd5: hdr_next_d = cks_q[15:8];
            3'd6: hdr_next_d = cks_q[7:0];
            default: hdr_next_d = 8'h00;
        endcase
    end

    // Datagram FSM: request latch, IPv4 arbitration with timeout, header then payload
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_port_q <= '0;
            dst_port_q <= '0;
            cks_q      <= '0;
            ipv4_len_q <= '0;
            dst_ip_q   <= '0;
            proto_q    <= '0;
            timer_q    <= '0;
            hdr_idx_q  <= '0;
            pld_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ipv4_req_q <= 1'b0;
            val_q      <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            pld_rd_q   <= 1'b0;
            hdr_dat_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            sof_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (len_ok_d) begin
                            src_port_q <= src_port;
                            dst_port_q <= dst_port;
                            cks_q      <= cks;
                            ipv4_len_q <= pld_len + 16'd8;
                            dst_ip_q   <= dst_ip;
                            proto_q    <= 8'd17;
                            busy_q     <= 1'b1;
                            ipv4_req_q <= 1'b1;
                            timer_q    <= '0;
                            state_q    <= S_REQ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // Acceptance takes priority over a timeout landing on the same cycle
                    if (ipv4_acc) begin
                        ipv4_req_q <= 1'b0;
                        val_q      <= 1'b1;
                        sof_q      <= 1'b1;
                        hdr_dat_q  <= src_port_q[15:8];
                        hdr_idx_q  <= 3'd0;
                        state_q    <= S_HDR;
                    end else if (timer_q == TW'(ACC_TIMEOUT - 1)) begin
                        ipv4_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_HDR: begin
                    if (hdr_idx_q == 3'd7) begin
                        hdr_dat_q <= 8'h00;
                        pld_rd_q  <= 1'b1;
                        pld_cnt_q <= ipv4_len_q - 16'd8;
                        eof_q     <= (ipv4_len_q == 16'd9);
                        state_q   <= S_PLD;
                    end else begin
                        hdr_dat_q <= hdr_next_d;
                        hdr_idx_q <= hdr_idx_q + 3'd1;
                    end
                end
                S_PLD: begin
                    // pld_cnt_q holds bytes remaining including the one on the stream now
                    if (pld_cnt_q == 16'd1) begin
                        val_q    <= 1'b0;
                        eof_q    <= 1'b0;
                        pld_rd_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        pld_cnt_q <= pld_cnt_q - 16'd1;
                        eof_q     <= (pld_cnt_q == 16'd2);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign pld_rd      = pld_rd_q;
    assign ipv4_req    = ipv4_req_q;
    assign ipv4_len    = ipv4_len_q;
    assign ipv4_proto  = proto_q;
    assign ipv4_dst_ip = dst_ip_q;
    assign ipv4_val    = val_q;
    assign ipv4_sof    = sof_q;
    assign ipv4_eof    = eof_q;
    // Payload bytes flow straight from the FWFT buffer; header bytes come from the register
    assign ipv4_dat    = pld_rd_q ? pld_dat : hdr_dat_q;

endmodule

// File: tb/tb_udp_vlg_tx.sv
// tb/tb_udp_vlg_tx.sv - scoreboard bench for udp_vlg_tx
module tb_udp_vlg_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] src_port = '0;
    logic [15:0] dst_port = '0;
    logic [15:0] pld_len = '0;
    logic [15:0] cks = '0;
    logic [31:0] dst_ip = '0;
    logic        busy, done, err;
    logic [7:0]  pld_dat = '0;
    logic        pld_rd;
    logic        ipv4_req;
    logic        ipv4_acc = 1'b0;
    logic [15:0] ipv4_len;
    logic [7:0]  ipv4_proto;
    logic [31:0] ipv4_dst_ip;
    logic [7:0]  ipv4_dat;
    logic        ipv4_val, ipv4_sof, ipv4_eof;

    typedef struct {
        logic [7:0]  dat;
        logic        sof;
        logic        eof;
        logic [15:0] len;
        logic [31:0] ip;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fifo[$];
    logic [7:0] pay[$];
    exp_t       mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_delay = 0;
    int req_cnt = 0;
    int sof_cyc = -1;
    int eof_cyc = -1;
    int rd_cnt = 0;
    bit mon_en = 1'b0;

    udp_vlg_tx #(.ACC_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .src_port(src_port), .dst_port(dst_port),
        .pld_len(pld_len), .cks(cks), .dst_ip(dst_ip), .busy(busy), .done(done), .err(err),
        .pld_dat(pld_dat), .pld_rd(pld_rd), .ipv4_req(ipv4_req), .ipv4_acc(ipv4_acc),
        .ipv4_len(ipv4_len), .ipv4_proto(ipv4_proto), .ipv4_dst_ip(ipv4_dst_ip),
        .ipv4_dat(ipv4_dat), .ipv4_val(ipv4_val), .ipv4_sof(ipv4_sof), .ipv4_eof(ipv4_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FWFT payload buffer model
    always @(posedge clk) begin
        if (pld_rd && fifo.size() > 0) void'(fifo.pop_front());
        #1;
        pld_dat = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end

    // IPv4 arbiter model: grants acc_delay cycles after ipv4_req rises (never if negative)
    always @(posedge clk) begin
        #1;
        ipv4_acc = (ipv4_req && acc_delay >= 0 && req_cnt == acc_delay);
        req_cnt  = ipv4_req ? req_cnt + 1 : 0;
    end

    // Stream monitor: pops the scoreboard for every valid byte
    always @(negedge clk) begin
        if (mon_en) begin
            if (ipv4_val && ipv4_sof) rd_cnt = 0;
            if (pld_rd) rd_cnt++;
            if (ipv4_val) begin
                if (ipv4_sof) sof_cyc = cyc;
                if (ipv4_eof) eof_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got dat=%02h sof=%0b eof=%0b expected no byte", ipv4_dat, ipv4_sof, ipv4_eof);
                end else begin
                    mon_e = sb.pop_front();
                    if ({ipv4_dat, ipv4_sof, ipv4_eof} !== {mon_e.dat, mon_e.sof, mon_e.eof}) begin
                        errors++;
                        $display("FAIL stream_byte got dat=%02h sof=%0b eof=%0b expected dat=%02h sof=%0b eof=%0b",
                                 ipv4_dat, ipv4_sof, ipv4_eof, mon_e.dat, mon_e.sof, mon_e.eof);
                    end
                    if (mon_e.sof) begin
                        checks++;
                        if (ipv4_len !== mon_e.len || ipv4_dst_ip !== mon_e.ip || ipv4_proto !== 8'd17) begin
                            errors++;
                            $display("FAIL meta got len=%0d ip=%08h proto=%0d expected len=%0d ip=%08h proto=17",
                                     ipv4_len, ipv4_dst_ip, ipv4_proto, mon_e.len, mon_e.ip);
                        end
                    end
                end
            end else begin
                checks++;
                if (ipv4_dat !== 8'h00 || ipv4_sof !== 1'b0 || ipv4_eof !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_stream got dat=%02h sof=%0b eof=%0b expected 00 0 0", ipv4_dat, ipv4_sof, ipv4_eof);
                end
            end
        end
    end

    task automatic push_dgram(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c, input logic [31:0] ip);
        logic [15:0] ul;
        logic [7:0]  h[8];
        exp_t        e;
        int          n;
        n  = pay.size();
        ul = 16'(n + 8);
        h  = '{s[15:8], s[7:0], d[15:8], d[7:0], ul[15:8], ul[7:0], c[15:8], c[7:0]};
        for (int i = 0; i < 8; i++) begin
            e.dat = h[i]; e.sof = (i == 0); e.eof = 1'b0; e.len = ul; e.ip = ip;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.dat = pay[i]; e.sof = 1'b0; e.eof = (i == n - 1); e.len = ul; e.ip = ip;
            sb.push_back(e);
            fifo.push_back(pay[i]);
        end
    endtask

    task automatic fill_random(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic set_meta(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input logic [15:0] c, input logic [31:0] ip);
        src_port = s; dst_port = d; pld_len = l; cks = c; dst_ip = ip;
    endtask

    task automatic pulse_req(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                             input logic [15:0] c, input logic [31:0] ip);
        @(posedge clk); #1;
        set_meta(s, d, l, c, ip);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, err, pld_rd, ipv4_req, ipv4_val, ipv4_sof, ipv4_eof} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %08b expected 00000000", {busy, done, err, pld_rd, ipv4_req, ipv4_val, ipv4_sof, ipv4_eof});
        end
        checks++;
        if (ipv4_dat !== 8'h00 || ipv4_len !== 16'h0 || ipv4_dst_ip !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got dat=%02h len=%0d ip=%08h expected all 0", ipv4_dat, ipv4_len, ipv4_dst_ip);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] t1[12];
        exp_t       e;
        bit         got;
        t1 = '{8'h04, 8'hD2, 8'h16, 8'h2E, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 12; i++) begin
            e.dat = t1[i]; e.sof = (i == 0); e.eof = (i == 11); e.len = 16'd12; e.ip = 32'hC0A8_0001;
            sb.push_back(e);
        end
        fifo.push_back(8'hDE); fifo.push_back(8'hAD); fifo.push_back(8'hBE); fifo.push_back(8'hEF);
        acc_delay = 3;
        pulse_req(16'd1234, 16'd5678, 16'd4, 16'd0, 32'hC0A8_0001);
        wait_done(60, got);
        checks++;
        if (got && (cyc !== eof_cyc + 1 || busy !== 1'b0)) begin
            errors++;
            $display("FAIL basic_done got done_cyc=%0d busy=%0b expected done_cyc=%0d busy=0", cyc, busy, eof_cyc + 1);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL basic_sb got %0d bytes left expected 0", sb.size());
        end
    endtask

    task automatic test_min_len();
        bit got;
        fill_random(1);
        push_dgram(16'hA1B2, 16'h0035, 16'hBEEF, 32'h0A00_0002);
        acc_delay = 0;
        pulse_req(16'hA1B2, 16'h0035, 16'd1, 16'hBEEF, 32'h0A00_0002);
        wait_done(60, got);
        checks++;
        if (eof_cyc - sof_cyc != 8 || rd_cnt != 1) begin
            errors++;
            $display("FAIL min_len got sof_to_eof=%0d rd_cycles=%0d expected 8 and 1", eof_cyc - sof_cyc, rd_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL min_len_sb got %0d bytes left expected 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        acc_delay = -1;
        pulse_req(16'd1, 16'd2, 16'd20, 16'd0, 32'h0102_0304);
        @(negedge clk);
        checks++;
        if (ipv4_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_req got ipv4_req=%0b busy=%0b expected 1 1", ipv4_req, busy);
        end
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (err) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 16 || busy !== 1'b0 || ipv4_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err got err_after=%0d busy=%0b ipv4_req=%0b expected 16 0 0", n, busy, ipv4_req);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse got err=%0b expected 0", err);
        end
        acc_delay = 0;
    endtask

    task automatic test_bad_len();
        logic [15:0] lens[2];
        lens = '{16'd0, 16'd1473};
        for (int k = 0; k < 2; k++) begin
            pulse_req(16'd7, 16'd8, lens[k], 16'd0, 32'hFFFF_0000);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || ipv4_req !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_%0d got err=%0b ipv4_req=%0b busy=%0b expected 1 0 0", lens[k], err, ipv4_req, busy);
            end
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || ipv4_req !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_after_%0d got err=%0b ipv4_req=%0b expected 0 0", lens[k], err, ipv4_req);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        bit got;
        fill_random(10);
        push_dgram(16'h1111, 16'h2222, 16'h3333, 32'h4444_5555);
        acc_delay = 1;
        pulse_req(16'h1111, 16'h2222, 16'd10, 16'h3333, 32'h4444_5555);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (pld_rd) cnt++;
            if (cnt == 3) break;
        end
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL rst_mid_reach got %0d payload bytes expected 3", cnt);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        fifo.delete();
        @(negedge clk);
        checks++;
        if ({busy, done, err, pld_rd, ipv4_req, ipv4_val, ipv4_sof, ipv4_eof} !== 8'h00 ||
            ipv4_dat !== 8'h00 || ipv4_len !== 16'h0 || ipv4_dst_ip !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got ctrl=%08b dat=%02h len=%0d ip=%08h expected all 0",
                     {busy, done, err, pld_rd, ipv4_req, ipv4_val, ipv4_sof, ipv4_eof}, ipv4_dat, ipv4_len, ipv4_dst_ip);
        end
        fill_random(6);
        push_dgram(16'h0050, 16'h1F90, 16'h0000, 32'hAC10_0001);
        pulse_req(16'h0050, 16'h1F90, 16'd6, 16'h0000, 32'hAC10_0001);
        wait_done(60, got);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_resend got %0d bytes left expected 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int t_done;
        int t_req;
        bit got2;
        fill_random(3);
        push_dgram(16'hC000, 16'h0001, 16'h1234, 32'h0B0B_0B0B);
        fill_random(5);
        push_dgram(16'hC001, 16'h0002, 16'h5678, 32'h0C0C_0C0C);
        acc_delay = 2;
        @(posedge clk); #1;
        set_meta(16'hC000, 16'h0001, 16'd3, 16'h1234, 32'h0B0B_0B0B);
        req = 1'b1;
        @(posedge clk); #1;
        set_meta(16'hC001, 16'h0002, 16'd5, 16'h5678, 32'h0C0C_0C0C);
        t_done = -1;
        t_req  = -1;
        got2   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done && t_done < 0) begin
                t_done = cyc;
            end else if (t_done >= 0 && t_req < 0 && ipv4_req) begin
                t_req = cyc;
                req = 1'b0;
            end else if (t_req >= 0 && done) begin
                got2 = 1'b1;
                break;
            end
        end
        req = 1'b0;
        checks++;
        if (t_done < 0 || t_req != t_done + 1) begin
            errors++;
            $display("FAIL b2b_req_rise got req2_cyc=%0d expected %0d", t_req, t_done + 1);
        end
        checks++;
        if (!got2 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_second got done2=%0b bytes_left=%0d expected 1 0", got2, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_len();
        test_timeout();
        test_bad_len();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
